// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the MMIO UART transmitter: register offsets, STATUS bits,
// FSM states, load/store size encodings and the load-extension helper.
package mmio_uart_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;
  localparam logic [1:0] OFF_DROP   = 2'd3;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Same sign/zero extension the data memory applies to loads.
  function automatic logic [31:0] load_extend(input logic [31:0] value, input logic [2:0] f3);
    case (f3)
      F3_B:    return {{24{value[7]}}, value[7:0]};
      F3_H:    return {{16{value[15]}}, value[15:0]};
      F3_BU:   return {24'd0, value[7:0]};
      F3_HU:   return {16'd0, value[15:0]};
      default: return value;
    endcase
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Generic single-clock FIFO with synchronous active-low reset; a push into a full
// FIFO is still accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wdata;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and registered read-back.
// Define MMIO_UART_STATS_EN to add the DROPCNT register and sticky overflow bit.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        irq_empty
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit, store_ok, tx_push, baud_we;
  logic [1:0]    reg_off;
  logic [15:0]   baud_wval, baud_div_reg;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  uart_state_t   state_reg, state_next;
  logic [7:0]    shift_reg, shift_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [15:0]   baud_cnt_reg, baud_cnt_next, div_q_reg, div_q_next;
  logic          tx_reg, tx_next, bit_end, irq_empty_reg;
  logic [31:0]   status_word, rd_word;
  logic          unused_bits;

  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16]};

  assign hit      = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_off  = mem_addr[3:2];
  assign store_ok = hit && mem_we && (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
  assign tx_push  = store_ok && (reg_off == OFF_TXDATA);
  assign baud_we  = store_ok && (reg_off == OFF_BAUD);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .wdata (mem_wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Byte stores only touch the low half of the divisor.
  always_comb begin
    baud_wval = mem_wdata[15:0];
    if (funct3 == F3_B) baud_wval = {baud_div_reg[15:8], mem_wdata[7:0]};
  end

  always_ff @(posedge clk) begin
    if (!reset)       baud_div_reg <= DEFAULT_DIV;
    else if (baud_we) baud_div_reg <= (baud_wval == 16'd0) ? 16'd1 : baud_wval;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      baud_cnt_reg  <= '0;
      div_q_reg     <= DEFAULT_DIV;
      tx_reg        <= 1'b1;
      irq_empty_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      baud_cnt_reg  <= baud_cnt_next;
      div_q_reg     <= div_q_next;
      tx_reg        <= tx_next;
      irq_empty_reg <= fifo_empty && (state_reg == IDLE);
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    baud_cnt_next = baud_cnt_reg;
    div_q_next    = div_q_reg;
    fifo_pop      = 1'b0;
    bit_end       = (baud_cnt_reg == 16'd0);
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          shift_next    = fifo_rdata;
          div_q_next    = baud_div_reg;
          baud_cnt_next = baud_div_reg - 16'd1;
          state_next    = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_next = div_q_reg - 16'd1;
          bit_cnt_next  = 3'd0;
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_next = div_q_reg - 16'd1;
          shift_next    = {1'b0, shift_reg[7:1]};
          bit_cnt_next  = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = STOP;
        end else begin
          baud_cnt_next = baud_cnt_reg - 16'd1;
        end
      end
      STOP: begin
        if (bit_end) state_next = IDLE;
        else         baud_cnt_next = baud_cnt_reg - 16'd1;
      end
      default: state_next = IDLE;
    endcase
    // tx is registered from the level of the state being entered.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign tx        = tx_reg;
  assign irq_empty = irq_empty_reg;

`ifdef MMIO_UART_STATS_EN
  logic [15:0] drop_cnt_reg;
  logic        ovf_reg;
  logic        drop_clr, drop_evt;

  assign drop_clr = store_ok && (reg_off == OFF_DROP);
  assign drop_evt = tx_push && fifo_full && !fifo_pop;

  always_ff @(posedge clk) begin
    if (!reset || drop_clr) begin
      drop_cnt_reg <= '0;
      ovf_reg      <= 1'b0;
    end else if (drop_evt) begin
      if (drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
      ovf_reg <= 1'b1;
    end
  end
`endif

  always_comb begin
    status_word                  = '0;
    status_word[STAT_BUSY]       = (state_reg != IDLE);
    status_word[STAT_FULL]       = fifo_full;
    status_word[STAT_EMPTY]      = fifo_empty;
    status_word[STAT_COUNT_LSB +: 8] = 8'(fifo_count);
`ifdef MMIO_UART_STATS_EN
    status_word[STAT_OVF]        = ovf_reg;
`endif
    rd_word = '0;
    case (reg_off)
      OFF_STATUS: rd_word = status_word;
      OFF_BAUD:   rd_word = {16'd0, baud_div_reg};
`ifdef MMIO_UART_STATS_EN
      OFF_DROP:   rd_word = {16'd0, drop_cnt_reg};
`endif
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)   mem_rdata <= '0;
    else if (hit) mem_rdata <= load_extend(rd_word, funct3);
    else          mem_rdata <= '0;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx: register access, frame timing,
// divisor latching, FIFO overflow, full-push-with-pop and reset abort.
module tb_mmio_uart_tx;
  import mmio_uart_pkg::*;

  localparam logic [31:0] A_TX   = 32'h1000_0000;
  localparam logic [31:0] A_ST   = 32'h1000_0004;
  localparam logic [31:0] A_BAUD = 32'h1000_0008;
  localparam logic [31:0] A_DROP = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_we = 1'b0;
  logic [2:0]  funct3 = F3_W;
  logic [31:0] mem_rdata;
  logic        tx;
  logic        irq_empty;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  mmio_uart_tx dut (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .funct3    (funct3),
    .mem_rdata (mem_rdata),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    mem_addr = a; mem_wdata = d; funct3 = f3; mem_we = 1'b1;
    tick();
    mem_we = 1'b0; mem_addr = '0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f3, output logic [31:0] d);
    mem_addr = a; funct3 = f3; mem_we = 1'b0;
    tick();
    d = mem_rdata;
    mem_addr = '0;
  endtask

  task automatic wait_fall(input int bound, output int n);
    n = 0;
    while (tx !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
  endtask

  // Starts on the first START cycle; optionally rewrites BAUD_DIV mid-frame.
  task automatic frame_check(input string tag, input logic [7:0] b, input int d,
                             input bit mid_en, input logic [31:0] mid_div);
    int   errs = 0;
    int   bit_idx;
    logic exp_tx;
    for (int t = 0; t < 10 * d; t++) begin
      bit_idx = t / d;
      if (bit_idx == 0)      exp_tx = 1'b0;
      else if (bit_idx == 9) exp_tx = 1'b1;
      else                   exp_tx = b[bit_idx-1];
      if (tx !== exp_tx) errs++;
      if (mid_en && t == 2) begin
        mem_addr = A_BAUD; mem_wdata = mid_div; funct3 = F3_W; mem_we = 1'b1;
      end else begin
        mem_we = 1'b0; mem_addr = '0;
      end
      tick();
    end
    check(tag, 32'(errs), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n, start_cyc, lows;

    // Reset and readback
    for (int i = 0; i < 5; i++) tick();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_irq", 32'(irq_empty), 32'd1);
    reset = 1'b1;
    load(A_ST, F3_W, rd);   check("status_after_reset", rd, 32'h0000_0004);
    load(A_BAUD, F3_W, rd); check("baud_after_reset", rd, 32'd16);
    load(A_TX, F3_W, rd);   check("txdata_reads_zero", rd, 32'd0);
    load(32'h2000_0008, F3_W, rd); check("miss_reads_zero", rd, 32'd0);
    check("idle_tx", 32'(tx), 32'd1);

    // Single byte 0x41 at DIV=16
    store(A_TX, 32'h0000_0041, F3_B);
    check("sb_tx_before_start", 32'(tx), 32'd1);
    wait_fall(4, n);
    check("sb_start_latency", 32'(n), 32'd1);
    check("sb_irq_busy", 32'(irq_empty), 32'd0);
    frame_check("sb_frame_0x41", 8'h41, 16, 1'b0, 32'd0);
    check("sb_idle_after_frame", 32'(tx), 32'd1);
    tick();
    check("sb_irq_back", 32'(irq_empty), 32'd1);

    // Divisor: zero maps to 1; mid-frame rewrite applies to the next frame
    store(A_BAUD, 32'd0, F3_W);
    load(A_BAUD, F3_W, rd); check("baud_zero_is_one", rd, 32'd1);
    store(A_BAUD, 32'd4, F3_W);
    store(A_TX, 32'h0000_00A5, F3_B);
    store(A_TX, 32'h0000_003C, F3_B);
    wait_fall(2, n);
    check("div4_start", 32'(n), 32'd0);
    frame_check("div4_frame_0xA5", 8'hA5, 4, 1'b1, 32'd8);
    wait_fall(4, n);
    check("frame_gap", 32'(n), 32'd1);
    frame_check("div8_frame_0x3C", 8'h3C, 8, 1'b0, 32'd0);
    load(A_BAUD, F3_W, rd); check("baud_now_8", rd, 32'd8);

    // Load extension and store-size rules on BAUD_DIV
    store(A_BAUD, 32'h0000_8081, F3_W);
    load(A_BAUD, F3_B, rd);  check("lb_sign", rd, 32'hFFFF_FF81);
    load(A_BAUD, F3_BU, rd); check("lbu_zero", rd, 32'h0000_0081);
    load(A_BAUD, F3_H, rd);  check("lh_sign", rd, 32'hFFFF_8081);
    load(A_BAUD, F3_HU, rd); check("lhu_zero", rd, 32'h0000_8081);
    store(A_BAUD, 32'h1234_5605, F3_B);
    load(A_BAUD, F3_W, rd);  check("sb_low_byte_only", rd, 32'h0000_8005);
    store(A_BAUD, 32'h0000_0007, 3'b011);
    load(A_BAUD, F3_W, rd);  check("bad_funct3_ignored", rd, 32'h0000_8005);
    store(A_ST, 32'hFFFF_FFFF, F3_W);
    load(A_ST, F3_W, rd);    check("status_store_ignored", rd, 32'h0000_0004);
    store(A_BAUD, 32'hFFFF_0000, F3_H);
    load(32'h1000_000B, F3_W, rd); check("sh_zero_low_addr_bits", rd, 32'd1);

    // FIFO overflow with DIV=1000 (frame stays in progress)
    store(A_BAUD, 32'd1000, F3_W);
    for (int i = 0; i < 16; i++) store(A_TX, 32'hAB00 + i, F3_W);
    load(A_ST, F3_W, rd); check("status_after_16", rd, 32'h0000_0F01);
    store(A_TX, 32'hAB10, F3_W);
    load(A_ST, F3_W, rd); check("status_after_17", rd, 32'h0000_1003);
    for (int i = 0; i < 3; i++) store(A_TX, 32'hCD00 + i, F3_W);
`ifdef MMIO_UART_STATS_EN
    load(A_ST, F3_W, rd);   check("status_after_20", rd, 32'h0000_100B);
    load(A_DROP, F3_W, rd); check("dropcnt_3", rd, 32'd3);
    store(A_DROP, 32'd0, F3_W);
    load(A_DROP, F3_W, rd); check("dropcnt_cleared", rd, 32'd0);
    load(A_ST, F3_W, rd);   check("ovf_cleared", rd, 32'h0000_1003);
`else
    load(A_ST, F3_W, rd);   check("status_after_20", rd, 32'h0000_1003);
    load(A_DROP, F3_W, rd); check("reserved_reads_zero", rd, 32'd0);
`endif

    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;

    // Full FIFO: push lands in the IDLE pop cycle (DIV=2, IDLE at cycle 22)
    store(A_BAUD, 32'd2, F3_W);
    for (int i = 0; i < 17; i++) store(A_TX, 32'd0, F3_H);
    for (int i = 0; i < 5; i++) tick();
    check("fullpop_pre_tx", 32'(tx), 32'd1);
    store(A_TX, 32'd0, F3_B);
    check("fullpop_start", 32'(tx), 32'd0);
    start_cyc = cyc;
    load(A_ST, F3_W, rd); check("fullpop_count16", rd, 32'h0000_1003);
`ifdef MMIO_UART_STATS_EN
    load(A_DROP, F3_W, rd); check("fullpop_no_drop", rd, 32'd0);
`endif

    // Reset during DATA bit 3 of an all-zero byte
    while (cyc < start_cyc + 8) tick();
    check("rst_pre_tx_low", 32'(tx), 32'd0);
    reset = 1'b0;
    tick();
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_irq", 32'(irq_empty), 32'd1);
    check("rst_mid_rdata", mem_rdata, 32'd0);
    tick(); tick();
    reset = 1'b1;
    load(A_ST, F3_W, rd); check("status_after_abort", rd, 32'h0000_0004);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx !== 1'b1) lows++;
      tick();
    end
    check("no_residual_frame", 32'(lows), 32'd0);
    load(A_BAUD, F3_W, rd); check("baud_reset_default", rd, 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data-memory port, inside the MMIO window.
- The CPU stores bytes to a TXDATA register. Bytes enter a small FIFO and are serialized 8N1, LSB first, on a single output line.
- Read-back of status and divisor registers uses the same one-cycle registered-read timing as data memory.
- Console/printf sink for benchmark runs such as Dhrystone.

Parameters:
- BASE_ADDR, 32'h1000_0000, base address of the register block; 16-byte aligned.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256.
- DEFAULT_DIV, 16'd16, reset value of BAUD_DIV (clocks per bit).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- mem_addr  in  32  CPU data address
- mem_wdata  in  32  CPU store data
- mem_we  in  1  store strobe, one cycle per store
- funct3  in  3  access size/sign, same encoding as loads/stores
- mem_rdata  out  32  registered read data
- tx  out  1  serial output, idle high
- irq_empty  out  1  high while FIFO empty and shifter idle

Behaviour:
- Reset is synchronous and active-low, on clk rising edge: reset=0 means reset. While reset=0:
  - tx=1, mem_rdata=0, irq_empty=1.
  - FIFO pointers and count cleared; FSM=IDLE.
  - BAUD_DIV=DEFAULT_DIV.
- Reset mid-frame aborts the frame: tx=1 from the first edge with reset=0, and queued bytes are lost.
- Hit decode: hit = (mem_addr[31:4] == BASE_ADDR[31:4]). Register offset = mem_addr[3:2]. mem_addr[1:0] is ignored.
- Register map:
  - 0x0 TXDATA: write-only, reads 0.
  - 0x4 STATUS: read-only.
    - bit0 busy (FSM!=IDLE).
    - bit1 full.
    - bit2 empty.
    - bits[15:8] count, zero-extended.
  - 0x8 BAUD_DIV: R/W, bits[15:0].
  - 0xC reserved / optional feature.
- Stores to TXDATA:
  - Any store width (SB/SH/SW) pushes mem_wdata[7:0].
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the byte is dropped silently.
- Stores to BAUD_DIV:
  - SW writes [15:0]; SH writes [15:0]; SB writes [7:0] only.
  - Writing 0 stores 1.
  - A new value takes effect at the next START; the current frame keeps its latched divisor.
- Stores to STATUS or with funct3 not in {000,001,010} are ignored.
- Reads:
  - mem_rdata is updated every clk edge: register value if hit, else 0.
  - This gives one-cycle latency, matching data memory.
  - funct3 sign/zero extension applies to the low byte/half as for data memory.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO not empty, pop the head into the shift register, latch BAUD_DIV into div_q, load baud_cnt=div_q-1, go to START. tx=1.
  - START: tx=0 for div_q clocks, then DATA with bit_cnt=0.
  - DATA: tx=shift[0] for div_q clocks per bit. Shift right at each bit end; bit_cnt increments. After bit 7, go to STOP.
  - STOP: tx=1 for div_q clocks, then IDLE.
  - Back-to-back frames: IDLE lasts exactly one cycle between frames when the FIFO is non-empty.
- Frame length is exactly 10*div_q clocks plus 1 IDLE cycle.
- tx is driven from a flop (glitch-free). The first START edge appears two cycles after the accepting store.
- Simultaneous push and pop when empty: the byte cannot bypass; it is popped on the next IDLE cycle.
- Pointers wrap modulo FIFO_DEPTH. Count is clog2(FIFO_DEPTH)+1 bits wide.
- irq_empty is registered: irq_empty = empty && FSM==IDLE.

Optional Feature:
- Macro: MMIO_UART_STATS_EN.
- Defined:
  - Offset 0xC is DROPCNT, a 16-bit saturating count of TXDATA pushes dropped due to full.
  - Any store to 0xC clears it.
  - STATUS bit3 = sticky overflow, cleared with DROPCNT.
- Undefined: 0xC reads 0, STATUS bit3 reads 0, stores to 0xC are ignored, and no counter logic is present.

Decomposition:
- Package mmio_uart_pkg:
  - Register offsets (OFF_TXDATA=2'd0, OFF_STATUS=2'd1, OFF_BAUD=2'd2, OFF_DROP=2'd3).
  - STATUS bit indices.
  - FSM state enum.
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- Sub-module sync_fifo: parameterized width/depth, push/pop/full/empty/count, synchronous active-low reset. It is reused later by an RX peripheral.

Test Plan:
- Reset and readback:
  - Hold reset=0 for 5 cycles, then release.
  - LW 0x1000_0004 returns 0x0000_0004 (empty, count 0).
  - LW 0x1000_0008 returns 16.
  - tx=1 throughout.
- Single byte:
  - SB 0x41 to 0x1000_0000 with DIV=16.
  - tx low at cycle+2 for 16 clocks.
  - Data bits 1,0,0,0,0,0,1,0 at 16 clocks each, then stop high.
  - Total frame 160 clocks; irq_empty returns to 1.
- Divisor change:
  - Write BAUD_DIV=0 and read it back: returns 1.
  - Queue 2 bytes with DIV=4, rewriting DIV=8 mid-frame-1.
  - Frame1 is 40 clocks, frame2 is 80 clocks, with a 1-cycle gap.
- FIFO overflow:
  - 20 SW stores back-to-back with DIV=1000.
  - STATUS count=16, full=1 after store 17.
  - With MMIO_UART_STATS_EN defined: DROPCNT=3; a store to 0xC clears it to 0.
- Full push with simultaneous pop:
  - FIFO full, and a store lands in the same cycle IDLE pops.
  - Store is accepted and count stays 16.
- Reset mid-frame:
  - Assert reset during DATA bit 3.
  - tx=1 next edge; after release, STATUS=0x4 and no residual frame is sent.
